sync_fifo_flow: RTL and testbench
=================================

Name: sync_fifo_flow

Overview:
- Single-clock, parametrised successor to the team's CDC FIFO, for interconnect paths where both sides share one clock.
- Arbitrary depth, not restricted to powers of two.
- Valid/ready handshakes on both sides, plus fill-level and almost-full/almost-empty flags for upstream throttling.
- Synchronous flush.
- Used inside converters and register slices to buffer AXI channel payloads (AW/W/B/AR/R).

Parameters:
- MEM_DEPTH, 4, number of storage entries; legal range 2..1024, any integer.
- DATA_WIDTH, 20, payload width in bits.
- AFULL_THRESH, 3, almostFull asserts when level >= this value; legal range 1..MEM_DEPTH.
- AEMPTY_THRESH, 1, almostEmpty asserts when level <= this value; legal range 0..MEM_DEPTH-1.
- LVL_W (local), $clog2(MEM_DEPTH+1), width of the level signals.

Ports:
- clk  in  1  sole clock; all logic samples on the rising edge.
- sysReset  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous clear of contents, active-high.
- infoInValid  in  1  write request.
- infoIn  in  DATA_WIDTH  write payload.
- readyForInfo  out  1  space available.
- infoOutValid  out  1  head entry valid.
- infoOut  out  DATA_WIDTH  head entry payload.
- readyForOut  in  1  consumer accepts head.
- level  out  LVL_W  current number of stored entries.
- almostFull  out  1  level >= AFULL_THRESH.
- almostEmpty  out  1  level <= AEMPTY_THRESH.
- maxLevel  out  LVL_W  high-water mark; present only with SYNC_FIFO_HWM_EN.

Behaviour:
- Reset: sysReset==0 at a rising edge clears wrPtr, rdPtr and level to 0. Resulting outputs:
  - readyForInfo=1, infoOutValid=0, almostFull=0 (unless AFULL_THRESH==0, which is illegal).
  - almostEmpty=1, level=0, maxLevel=0.
  - infoOut is don't-care while infoOutValid=0.
- Reset mid-operation drops all contents; memory array contents are not cleared.
- Handshakes:
  - Write accepted (we) when infoInValid & readyForInfo.
  - Read accepted (re) when infoOutValid & readyForOut.
  - Producer may hold infoInValid asserted with readyForInfo low; nothing is written.
- readyForInfo = (level != MEM_DEPTH) and infoOutValid = (level != 0). Both are decoded from registered level only, so there is no combinational path from infoInValid to infoOutValid or from readyForOut to readyForInfo.
- Latency: a word written at edge N is presented at infoOut with infoOutValid=1 after edge N (one cycle) when the FIFO was empty.
- infoOut = mem[rdPtr]. It is stable while infoOutValid=1 and not re.
- Pointers: each increments on its accept and wraps from MEM_DEPTH-1 to 0 (explicit compare, not power-of-2 overflow).
- Level update per cycle:
  - +1 on we only.
  - -1 on re only.
  - Unchanged on both or neither.
- Full (level==MEM_DEPTH): writes are blocked even if a read occurs in the same cycle. readyForInfo rises the cycle after the read.
- Empty: a read is impossible; a write makes infoOutValid=1 next cycle.
- Simultaneous we & re at 0 < level < MEM_DEPTH: both pointers advance and level holds.
- flush=1 (sysReset=1): at the edge, pointers and level go to 0 and any same-cycle we/re is discarded. maxLevel is not affected.
- Reset has priority over flush.
- almostFull/almostEmpty are combinational compares on the level register.
- Storage is a register array written on clk; one write port, one asynchronous read port.

Optional Feature:
- Macro SYNC_FIFO_HWM_EN.
- When defined:
  - maxLevel port exists.
  - maxLevel updates to the next-cycle level whenever that exceeds the current maxLevel.
  - It is cleared only by sysReset, not by flush.
- When undefined: the port and its register are absent and there is no other behavioural difference.

Decomposition:
- Shared package sync_fifo_pkg holds:
  - The level-width helper (clog2 of depth+1).
  - Default parameter constants.
- Sub-module sync_fifo_ptr: a wrapping modulo-MEM_DEPTH counter with inc and clr inputs, instantiated twice (write and read pointers).

Test Plan:
- Reset/flags: MEM_DEPTH=4, hold sysReset=0 for 3 cycles then release -> level=0, readyForInfo=1, infoOutValid=0, almostEmpty=1, almostFull=0.
- Fill and block: write 0x1,0x2,0x3,0x4 on consecutive cycles with readyForOut=0 -> level=4, readyForInfo=0, almostFull=1 from level 3. A 5th write of 0x5 is not stored.
- Non-power-of-2 wrap: MEM_DEPTH=5, stream 12 words 0..11 with random valid/ready stalls -> output order 0..11 exactly, level never exceeds 5.
- Full with simultaneous read/write: at level=4 (depth 4) drive infoInValid=1 and readyForOut=1 -> read of head occurs, write is blocked that cycle, level=3. Next cycle the write is accepted and level stays 3.
- Flush mid-stream: level=3, assert flush with infoInValid=1 and readyForOut=1 -> next cycle level=0, infoOutValid=0. Subsequent write 0xA appears at infoOut after one cycle.
- HWM (SYNC_FIFO_HWM_EN): write 3, read 3, flush, write 1 -> maxLevel=3. After sysReset, maxLevel=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the single-clock flow-control FIFO.
package sync_fifo_pkg;

    localparam int DEF_MEM_DEPTH     = 4;
    localparam int DEF_DATA_WIDTH    = 20;
    localparam int DEF_AFULL_THRESH  = 3;
    localparam int DEF_AEMPTY_THRESH = 1;

    // Level counts 0..depth inclusive, hence depth+1 states.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Modulo-DEPTH wrapping pointer with synchronous clear and increment.
module sync_fifo_ptr
    import sync_fifo_pkg::*;
#(
    parameter int   DEPTH = DEF_MEM_DEPTH,
    localparam int  PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             sysReset,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_nxt_s;

    // Next pointer: clear wins over increment; wrap by explicit compare so any depth works.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (clr) begin
            ptr_nxt_s = {PTR_W{1'b0}};
        end else if (inc) begin
            if (ptr_r == PTR_W'(DEPTH - 1)) begin
                ptr_nxt_s = {PTR_W{1'b0}};
            end else begin
                ptr_nxt_s = ptr_r + PTR_W'(1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!sysReset) begin
            ptr_r <= {PTR_W{1'b0}};
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/sync_fifo_flow.sv
// Single-clock valid/ready FIFO of arbitrary depth with level and almost flags.
// Optional high-water mark output enabled by defining SYNC_FIFO_HWM_EN.
module sync_fifo_flow
    import sync_fifo_pkg::*;
#(
    parameter int   MEM_DEPTH     = DEF_MEM_DEPTH,
    parameter int   DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int   AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int   AEMPTY_THRESH = DEF_AEMPTY_THRESH,
    localparam int  LVL_W         = lvl_width(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  sysReset,
    input  logic                  flush,
    input  logic                  infoInValid,
    input  logic [DATA_WIDTH-1:0] infoIn,
    output logic                  readyForInfo,
    output logic                  infoOutValid,
    output logic [DATA_WIDTH-1:0] infoOut,
    input  logic                  readyForOut,
    output logic [LVL_W-1:0]      level,
`ifdef SYNC_FIFO_HWM_EN
    output logic [LVL_W-1:0]      maxLevel,
`endif
    output logic                  almostFull,
    output logic                  almostEmpty
);

    localparam int PTR_W = ptr_width(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_s;
    logic [PTR_W-1:0]      rd_ptr_s;
    logic [LVL_W-1:0]      level_r;
    logic [LVL_W-1:0]      level_nxt_s;
    logic                  we_s;
    logic                  re_s;
    logic                  mem_wr_s;

    // Flow flags come only from the level register, keeping valid/ready paths registered.
    assign readyForInfo = (level_r != LVL_W'(MEM_DEPTH));
    assign infoOutValid = (level_r != {LVL_W{1'b0}});
    assign almostFull   = (level_r >= LVL_W'(AFULL_THRESH));
    assign almostEmpty  = (level_r <= LVL_W'(AEMPTY_THRESH));
    assign level        = level_r;

    assign we_s     = infoInValid & readyForInfo;
    assign re_s     = infoOutValid & readyForOut;
    assign mem_wr_s = we_s & sysReset & ~flush;

    sync_fifo_ptr #(.DEPTH(MEM_DEPTH)) u_wr_ptr (
        .clk      (clk),
        .sysReset (sysReset),
        .clr      (flush),
        .inc      (we_s),
        .ptr      (wr_ptr_s)
    );

    sync_fifo_ptr #(.DEPTH(MEM_DEPTH)) u_rd_ptr (
        .clk      (clk),
        .sysReset (sysReset),
        .clr      (flush),
        .inc      (re_s),
        .ptr      (rd_ptr_s)
    );

    // Next level: flush empties; a simultaneous read and write cancel out.
    always_comb begin
        level_nxt_s = level_r;
        if (flush) begin
            level_nxt_s = {LVL_W{1'b0}};
        end else begin
            case ({we_s, re_s})
                2'b10:   level_nxt_s = level_r + LVL_W'(1);
                2'b01:   level_nxt_s = level_r - LVL_W'(1);
                default: level_nxt_s = level_r;
            endcase
        end
    end

    // Level register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!sysReset) begin
            level_r <= {LVL_W{1'b0}};
        end else begin
            level_r <= level_nxt_s;
        end
    end

    // Storage array; contents survive reset and flush, only pointers are cleared.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            mem_r[wr_ptr_s] <= infoIn;
        end else begin
            mem_r[wr_ptr_s] <= mem_r[wr_ptr_s];
        end
    end

    assign infoOut = mem_r[rd_ptr_s];

`ifdef SYNC_FIFO_HWM_EN
    logic [LVL_W-1:0] max_level_r;

    // High-water mark tracks the peak upcoming level; flush leaves it untouched.
    always_ff @(posedge clk) begin
        if (!sysReset) begin
            max_level_r <= {LVL_W{1'b0}};
        end else if (level_nxt_s > max_level_r) begin
            max_level_r <= level_nxt_s;
        end else begin
            max_level_r <= max_level_r;
        end
    end

    assign maxLevel = max_level_r;
`endif

endmodule

// File: tb/tb_sync_fifo_flow.sv
// Self-checking bench: queue-based reference model for a depth-4 and a depth-5 instance.
module tb_sync_fifo_flow;

    logic        clk;
    logic        sysReset;
    logic        flush;
    logic        vin  [2];
    logic [19:0] din  [2];
    logic        rdy  [2];
    logic        rfi  [2];
    logic        vld  [2];
    logic [19:0] dout [2];
    logic [2:0]  lvl  [2];
    logic [2:0]  maxl [2];
    logic        af   [2];
    logic        ae   [2];

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_en = 1'b0;

    localparam int DEP [2] = '{4, 5};
    localparam int AFT [2] = '{3, 4};
    localparam int AET [2] = '{1, 1};

    logic [19:0] mq [2][$];
    int          hwm [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_flow #(.MEM_DEPTH(4), .DATA_WIDTH(20), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_dut4 (
        .clk(clk), .sysReset(sysReset), .flush(flush),
        .infoInValid(vin[0]), .infoIn(din[0]), .readyForInfo(rfi[0]),
        .infoOutValid(vld[0]), .infoOut(dout[0]), .readyForOut(rdy[0]),
        .level(lvl[0]),
`ifdef SYNC_FIFO_HWM_EN
        .maxLevel(maxl[0]),
`endif
        .almostFull(af[0]), .almostEmpty(ae[0])
    );

    sync_fifo_flow #(.MEM_DEPTH(5), .DATA_WIDTH(20), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) u_dut5 (
        .clk(clk), .sysReset(sysReset), .flush(flush),
        .infoInValid(vin[1]), .infoIn(din[1]), .readyForInfo(rfi[1]),
        .infoOutValid(vld[1]), .infoOut(dout[1]), .readyForOut(rdy[1]),
        .level(lvl[1]),
`ifdef SYNC_FIFO_HWM_EN
        .maxLevel(maxl[1]),
`endif
        .almostFull(af[1]), .almostEmpty(ae[1])
    );

`ifndef SYNC_FIFO_HWM_EN
    assign maxl[0] = 3'd0;
    assign maxl[1] = 3'd0;
`endif

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d] t=%0t actual=%0h required=%0h", name, inst, $time, act, exp);
        end
    endtask

    // Reference model: FIFO as a queue, updated with the handshake rules at each edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!sysReset) begin
                mq[i].delete();
                hwm[i] = 0;
            end else if (flush) begin
                mq[i].delete();
            end else begin
                bit w;
                bit r;
                w = vin[i] && (mq[i].size() < DEP[i]);
                r = rdy[i] && (mq[i].size() > 0);
                if (r) void'(mq[i].pop_front());
                if (w) mq[i].push_back(din[i]);
                if (mq[i].size() > hwm[i]) hwm[i] = mq[i].size();
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int n;
                n = mq[i].size();
                chk("level", i, 32'(lvl[i]), 32'(n));
                chk("readyForInfo", i, 32'(rfi[i]), 32'(n != DEP[i]));
                chk("infoOutValid", i, 32'(vld[i]), 32'(n != 0));
                chk("almostFull", i, 32'(af[i]), 32'(n >= AFT[i]));
                chk("almostEmpty", i, 32'(ae[i]), 32'(n <= AET[i]));
                if (n != 0) chk("infoOut", i, 32'(dout[i]), 32'(mq[i][0]));
`ifdef SYNC_FIFO_HWM_EN
                chk("maxLevel", i, 32'(maxl[i]), 32'(hwm[i]));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [15:0] vpat;
    logic [15:0] rpat;
    logic [19:0] rx [$];
    int          wi;
    int          cyc;
    bit          wacc;
    bit          racc;

    initial begin
        sysReset = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vin[i] = 1'b0;
            din[i] = 20'h0;
            rdy[i] = 1'b0;
        end
        repeat (3) step();
        sysReset = 1'b1;
        chk_en = 1'b1;
        chk("rst_level", 0, 32'(lvl[0]), 32'd0);
        chk("rst_readyForInfo", 0, 32'(rfi[0]), 32'd1);
        chk("rst_infoOutValid", 0, 32'(vld[0]), 32'd0);
        chk("rst_almostEmpty", 0, 32'(ae[0]), 32'd1);
        chk("rst_almostFull", 0, 32'(af[0]), 32'd0);

        // Fill depth-4 instance with the consumer stalled.
        vin[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            din[0] = 20'(k);
            step();
            if (k == 3) begin
                chk("fill3_level", 0, 32'(lvl[0]), 32'd3);
                chk("fill3_almostFull", 0, 32'(af[0]), 32'd1);
            end
        end
        chk("full_level", 0, 32'(lvl[0]), 32'd4);
        chk("full_readyForInfo", 0, 32'(rfi[0]), 32'd0);
        din[0] = 20'h5;
        step();
        chk("blocked_level", 0, 32'(lvl[0]), 32'd4);
        chk("blocked_head", 0, 32'(dout[0]), 32'h1);

        // Full with simultaneous read and write: write is refused this cycle.
        rdy[0] = 1'b1;
        step();
        chk("fullrw_level", 0, 32'(lvl[0]), 32'd3);
        chk("fullrw_head", 0, 32'(dout[0]), 32'h2);
        chk("fullrw_ready", 0, 32'(rfi[0]), 32'd1);
        step();
        chk("rw_level", 0, 32'(lvl[0]), 32'd3);
        chk("rw_head", 0, 32'(dout[0]), 32'h3);

        // Flush at level 3 with both handshakes active.
        flush = 1'b1;
        din[0] = 20'h6;
        step();
        chk("flush_level", 0, 32'(lvl[0]), 32'd0);
        chk("flush_valid", 0, 32'(vld[0]), 32'd0);
        flush = 1'b0;
        rdy[0] = 1'b0;
        din[0] = 20'hA;
        step();
        vin[0] = 1'b0;
        chk("postflush_valid", 0, 32'(vld[0]), 32'd1);
        chk("postflush_data", 0, 32'(dout[0]), 32'hA);

        // High-water mark sequence: write 3, read 3, flush, write 1.
        sysReset = 1'b0;
        step();
        sysReset = 1'b1;
        vin[0] = 1'b1;
        for (int k = 7; k <= 9; k++) begin
            din[0] = 20'(k);
            step();
        end
        vin[0] = 1'b0;
        rdy[0] = 1'b1;
        repeat (3) step();
        chk("drained_level", 0, 32'(lvl[0]), 32'd0);
        rdy[0] = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        vin[0] = 1'b1;
        din[0] = 20'hB;
        step();
        vin[0] = 1'b0;
        chk("hwm_seq_level", 0, 32'(lvl[0]), 32'd1);
`ifdef SYNC_FIFO_HWM_EN
        chk("hwm_peak", 0, 32'(maxl[0]), 32'd3);
`endif
        sysReset = 1'b0;
        step();
        sysReset = 1'b1;
`ifdef SYNC_FIFO_HWM_EN
        chk("hwm_reset", 0, 32'(maxl[0]), 32'd0);
`endif
        chk("reset_drop_level", 0, 32'(lvl[0]), 32'd0);

        // Depth-5 stream of 0..11 with valid/ready stalls, reader stalled first to reach full.
        vpat = 16'b1011_0111_1110_1101;
        rpat = 16'b0110_0011_1101_0001;
        wi = 0;
        cyc = 0;
        while ((rx.size() < 12) && (cyc < 300)) begin
            vin[1] = (wi < 12) && vpat[cyc % 16];
            din[1] = 20'(wi);
            rdy[1] = (cyc >= 7) && (rpat[cyc % 16] || (cyc > 40));
            #1;
            wacc = vin[1] && rfi[1];
            racc = vld[1] && rdy[1];
            if (racc) rx.push_back(dout[1]);
            step();
            if (wacc) wi++;
            cyc++;
        end
        vin[1] = 1'b0;
        rdy[1] = 1'b0;
        chk("stream_count", 1, 32'(rx.size()), 32'd12);
        for (int k = 0; k < rx.size(); k++) begin
            chk("stream_order", 1, 32'(rx[k]), 32'(k));
        end
        step();
        chk("stream_end_level", 1, 32'(lvl[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
